// File: rtl/cond_merge_pkg.sv
// cond_merge_pkg: shared definitions for the three-way conditional merge.
//   SRC_W          width of the branch-origin tag
//   SRC_B0..SRC_B2 tag values for branches 0..2 (3 is never used)
//   merge_entry_t  {src, data} FIFO entry at the default 32-bit payload width
//   next_src()     round-robin successor of a branch tag, mod 3
package cond_merge_pkg;

  localparam int unsigned SRC_W          = 2;
  localparam int unsigned DEFAULT_DATA_W = 32;

  typedef logic [SRC_W-1:0] src_t;

  localparam src_t SRC_B0 = 2'd0;
  localparam src_t SRC_B1 = 2'd1;
  localparam src_t SRC_B2 = 2'd2;

  // The top level declares a width-matched copy of this layout for its DATA_W.
  typedef struct packed {
    src_t                      src;
    logic [DEFAULT_DATA_W-1:0] data;
  } merge_entry_t;

  function automatic src_t next_src(input src_t k);
    return (k == SRC_B2) ? SRC_B0 : src_t'(k + src_t'(1));
  endfunction

endpackage

// File: rtl/cond_merge_fifo.sv
// cond_merge_fifo: synchronous FIFO with occupancy output, no fall-through.
//   clk_i, rst_ni  clock, asynchronous active-low reset (clears pointers and level)
//   push_i/wdata_i write request and word; ignored when full
//   pop_i          read request; ignored when empty
//   rdata_o        head word, 0 when empty
//   empty_o/full_o occupancy flags
//   level_o        number of stored words, 0..Depth
module cond_merge_fifo #(
  parameter int unsigned Width = 34,
  parameter int unsigned Depth = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         rdata_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(Depth):0]   level_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned LvlW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]  level_q, level_d;
  logic             do_push, do_pop;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LvlW'(Depth));
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    level_d = level_q;
    unique case ({do_push, do_pop})
      2'b10:   level_d = level_q + LvlW'(1);
      2'b01:   level_d = level_q - LvlW'(1);
      default: level_d = level_q;
    endcase
  end

  // Pointers are exactly PtrW bits wide so they wrap at Depth on their own.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      level_q <= level_d;
    end
  end

  // Storage is not reset; stale words are masked by the level.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];
  assign level_o = level_q;

endmodule

// File: rtl/cond_merge3.sv
// cond_merge3: round-robin merge of three branch channels into one tagged stream,
// buffered by an output FIFO so a stalled consumer does not stall the branches.
//   clk, rst_n            clock, asynchronous active-low reset
//   inK_valid/ready/data  branch K handshake and payload (K = 0..2)
//   out_valid/ready       FIFO head handshake
//   out_data, out_src     head payload and branch of origin (0 when empty)
//   fifo_level            current FIFO occupancy
module cond_merge3
  import cond_merge_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in0_valid,
  input  logic                     in1_valid,
  input  logic                     in2_valid,
  output logic                     in0_ready,
  output logic                     in1_ready,
  output logic                     in2_ready,
  input  logic [DATA_W-1:0]        in0_data,
  input  logic [DATA_W-1:0]        in1_data,
  input  logic [DATA_W-1:0]        in2_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [SRC_W-1:0]         out_src,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  typedef struct packed {
    src_t              src;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic [2:0] valid_vec, grant;
  src_t       rr_ptr_q, rr_ptr_d;
  entry_t     wr_entry, rd_entry;
  logic       fifo_full, fifo_empty;

  assign valid_vec = {in2_valid, in1_valid, in0_valid};

  // Full is taken from the registered level, so a pop in the same cycle never
  // opens a slot for a push (no out_ready -> inK_ready path).
  always_comb begin
    grant = '0;
    if (!fifo_full) begin
      case (rr_ptr_q)
        SRC_B0: begin
          if      (valid_vec[0]) grant = 3'b001;
          else if (valid_vec[1]) grant = 3'b010;
          else if (valid_vec[2]) grant = 3'b100;
        end
        SRC_B1: begin
          if      (valid_vec[1]) grant = 3'b010;
          else if (valid_vec[2]) grant = 3'b100;
          else if (valid_vec[0]) grant = 3'b001;
        end
        default: begin
          if      (valid_vec[2]) grant = 3'b100;
          else if (valid_vec[0]) grant = 3'b001;
          else if (valid_vec[1]) grant = 3'b010;
        end
      endcase
    end
  end

  always_comb begin
    rr_ptr_d      = rr_ptr_q;
    wr_entry.src  = SRC_B0;
    wr_entry.data = in0_data;
    unique case (grant)
      3'b001: begin
        rr_ptr_d      = next_src(SRC_B0);
        wr_entry.src  = SRC_B0;
        wr_entry.data = in0_data;
      end
      3'b010: begin
        rr_ptr_d      = next_src(SRC_B1);
        wr_entry.src  = SRC_B1;
        wr_entry.data = in1_data;
      end
      3'b100: begin
        rr_ptr_d      = next_src(SRC_B2);
        wr_entry.src  = SRC_B2;
        wr_entry.data = in2_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= SRC_B0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  cond_merge_fifo #(
    .Width ($bits(entry_t)),
    .Depth (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (|grant),
    .wdata_i (wr_entry),
    .pop_i   (out_ready),
    .rdata_o (rd_entry),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .level_o (fifo_level)
  );

  assign in0_ready = grant[0];
  assign in1_ready = grant[1];
  assign in2_ready = grant[2];

  assign out_valid = ~fifo_empty;
  assign out_data  = rd_entry.data;
  assign out_src   = rd_entry.src;

endmodule

// File: doc/cond_merge3.md
# cond_merge3

Synchronous three-way round-robin merge that sits directly downstream of the three-output conditional fork. It collects the branch channels `in0..in2` back into one stream, tags each word with the branch it came from, and buffers results in a small FIFO so a stalled consumer does not stall the fork.

## Interface
Parameters:
- `DATA_W`, 32: payload width per branch.
- `DEPTH`, 4: output FIFO entries; must be a power of two and at least 2.

Ports:
- `clk`  in  1  the single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `in0_valid`, `in1_valid`, `in2_valid`  in  1 each  branch k offers a word.
- `in0_ready`, `in1_ready`, `in2_ready`  out  1 each  branch k word is accepted this cycle.
- `in0_data`, `in1_data`, `in2_data`  in  `DATA_W` each  branch k payload.
- `out_valid`  out  1  FIFO head is valid.
- `out_ready`  in  1  consumer accepts the head.
- `out_data`  out  `DATA_W`  head payload.
- `out_src`  out  2  head origin: 0, 1 or 2. The value 3 is never produced.
- `fifo_level`  out  `$clog2(DEPTH)+1`  current occupancy.

## Operation
- **Handshake.** A transfer happens on any edge where valid and ready are both high. `inK_ready` may depend combinationally on the `inX_valid` inputs. It never depends on `out_ready`, so there is no combinational path from output to input.
- **Arbitration.**
  - The round-robin pointer `rr_ptr` takes values 0..2; its reset value is 0.
  - Priority order is `rr_ptr`, `rr_ptr+1`, `rr_ptr+2`, each mod 3.
  - Grant is one-hot: the highest-priority valid branch, and only when `fifo_level < DEPTH`.
  - `inK_ready = grant[K]`. At most one input is accepted per cycle.
  - After a grant to branch k, `rr_ptr` becomes (k+1) mod 3. With no grant, `rr_ptr` holds.
- **FIFO.**
  - Each entry stores {src, data}.
  - Read and write pointers have `$clog2(DEPTH)` bits and wrap naturally at `DEPTH`.
  - `fifo_level` counts +1 on a push, -1 on a pop, and is unchanged when both happen in the same cycle.
  - `out_valid = (fifo_level != 0)`.
  - `out_data` and `out_src` show the head entry and are forced to 0 when the FIFO is empty.
- **Full.** At `fifo_level == DEPTH`, all `inK_ready` are 0 even if `out_ready` is 1 in the same cycle (registered-full policy, so there is no bypass).
- **Empty.** A pop is ignored when `out_valid` is 0. There is no fall-through: a word accepted at edge N is visible at the output from N+1.
- **Reset, including mid-operation.** Asserting `rst_n` low immediately clears both pointers, `fifo_level` and `rr_ptr`. Buffered words are discarded. Memory contents need not be reset.

## Timing
Reset values:
- `out_valid`, `out_data`, `out_src`, `fifo_level`: all 0.
- `inK_ready`: 0 when `inK_valid` is low.

Latency:
- Input accept to `out_valid`: 1 cycle.
- Throughput: 1 word/cycle sustained when `out_ready` is held high and at least one branch is valid.
- With all three branches continuously valid, grants rotate 0, 1, 2, 0, ...
- A branch that is valid but not granted waits at most 2 grant cycles.

## Structure
- Shared package `cond_merge_pkg`:
  - `SRC_W = 2`.
  - Constants `SRC_B0`, `SRC_B1`, `SRC_B2` = 0, 1, 2.
  - Typedef for the FIFO entry struct {src, data}.
- Natural sub-module: `cond_merge_fifo`, a parameterised synchronous FIFO with async active-low reset and a level output.
- Arbiter and pointer logic stay in the top level.

## Test plan
1. **Reset.** Hold `rst_n`=0, drive all valids=1 → `out_valid`=0, `fifo_level`=0, `out_data`=0. Release, keep `out_ready`=1 → grants in order 0, 1, 2, 0, 1, 2 and `out_src` follows one cycle later.
2. **Single branch.** Only `in1_valid`=1 with `in1_data`=0xA5 → `in1_ready`=1 in that cycle; next cycle `out_valid`=1, `out_data`=0xA5, `out_src`=1, `fifo_level`=1.
3. **Backpressure.** `out_ready`=0, all branches valid, `DEPTH`=4 → exactly 4 accepts with src 0, 1, 2, 0. Then all readies are 0 and `fifo_level`=4, including in a cycle where `out_ready` rises. Set `out_ready`=1 → words drain in accept order.
4. **Push and pop together.** At `fifo_level`=1, push and pop in the same cycle → level stays 1 and the pointers advance with wrap past index 3 back to 0.
5. **Fairness with two branches.** Only `in0` and `in2` valid, starting from `rr_ptr`=0 → grant order 0, 2, 0, 2; branch 1 is never granted.
6. **Mid-operation reset.** Drop `rst_n` with `fifo_level`=3 → `out_valid`, `fifo_level`, `out_data` and `out_src` go to 0 without waiting for a clock edge. After release, the first grant goes to branch 0.
